// File: rtl/mem_responder_if.sv
// Request/response bus between a cache and its backing memory responder.
// master = cache side, slave = responder side.
interface mem_responder_if;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  modport master (
    input  mem_ready, mem_rdata, mem_valid,
    output mem_addr, mem_ren, mem_wen, mem_wdata
  );

  modport slave (
    output mem_ready, mem_rdata, mem_valid,
    input  mem_addr, mem_ren, mem_wen, mem_wdata
  );
endinterface

// File: rtl/mem_responder.sv
// Word-granular backing memory with fixed-latency, in-order pipelined reads.
// Optional pseudo-random backpressure: define MEM_RESPONDER_STALL_EN.
module mem_responder #(
  parameter int           ADDR_W          = 10,
  parameter int           READ_LATENCY    = 2,
  parameter int           MAX_OUTSTANDING = 4,
  parameter logic [7:0]   LFSR_SEED       = 8'hA5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mem_responder_if.slave mem_if
);

  localparam int         L     = READ_LATENCY;
  localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

  logic [31:0]       mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              en_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [L-1:0]      vld_q;
  logic [31:0]       dat_q [L];
  logic              tail, stall, ready;
  logic              acc_rd, acc_wr;
  logic              unused_addr;

  assign idx = mem_if.mem_addr[ADDR_W+1:2];
  assign unused_addr = ^{mem_if.mem_addr[31:ADDR_W+2],
                         mem_if.mem_addr[1:0]};

  // The returning read frees its slot in the same cycle it is presented.
  assign tail   = vld_q[L-1];
  assign ready  = en_q && ((cnt_q - {3'b0, tail}) < MAX_O) && !stall;
  assign acc_wr = ready && mem_if.mem_wen;
  assign acc_rd = ready && mem_if.mem_ren && !mem_if.mem_wen;
  assign cnt_d  = cnt_q + {3'b0, acc_rd} - {3'b0, tail};

`ifdef MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign stall  = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  localparam logic [7:0] unused_seed = LFSR_SEED;
  assign stall = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (acc_wr) mem_q[idx] <= mem_if.mem_wdata;
  end

  // Data stages only move behind a valid, so the tail holds its last value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      en_q  <= 1'b0;
      cnt_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < L; i++) dat_q[i] <= '0;
    end else begin
      en_q     <= 1'b1;
      cnt_q    <= cnt_d;
      vld_q[0] <= acc_rd;
      if (acc_rd) dat_q[0] <= mem_q[idx];
      for (int i = 1; i < L; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign mem_if.mem_ready = ready;
  assign mem_if.mem_valid = tail;
  assign mem_if.mem_rdata = dat_q[L-1];

endmodule
